// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rf_wb_arbiter                                                 |
// | Purpose  : Write-back arbiter (ALU vs. load unit) for the integer        |
// |            register file plus pending-destination scoreboard for RAW     |
// |            hazard checks. WB_RR_ARB_EN selects round-robin contention    |
// |            resolution; otherwise the load unit has fixed priority.       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rf_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [AW-1:0]     a_rd,
  input  logic [XLEN-1:0]   a_data,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [AW-1:0]     m_rd,
  input  logic [XLEN-1:0]   m_data,
  output logic              reg_write,
  output logic [AW-1:0]     rd,
  output logic [XLEN-1:0]   write_data,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [2**AW-1:0]  pending
);

  localparam int NREG = 2**AW;

  logic              w_a_grant;
  logic              w_m_grant;
  logic [AW-1:0]     w_win_rd;
  logic [XLEN-1:0]   w_win_data;
  logic [NREG-1:0]   w_pending_nxt;

  logic              r_reg_write;
  logic [AW-1:0]     r_rd;
  logic [XLEN-1:0]   r_write_data;
  logic [NREG-1:0]   r_pending;

`ifdef WB_RR_ARB_EN
  // Set when the ALU was granted last, so the load unit wins the next contention.
  logic r_prefer_m;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prefer_m <= 1'b0;
    end else if (w_a_grant) begin
      r_prefer_m <= 1'b1;
    end else if (w_m_grant) begin
      r_prefer_m <= 1'b0;
    end
  end

  assign w_a_grant = !reset && a_valid && !(m_valid && r_prefer_m);
  assign w_m_grant = !reset && m_valid && !(a_valid && !r_prefer_m);
`else
  assign w_a_grant = !reset && a_valid && !m_valid;
  assign w_m_grant = !reset && m_valid;
`endif

  assign a_ready    = w_a_grant;
  assign m_ready    = w_m_grant;
  assign w_win_rd   = w_a_grant ? a_rd   : m_rd;
  assign w_win_data = w_a_grant ? a_data : m_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_rd         <= '0;
      r_write_data <= '0;
    end else if (w_a_grant || w_m_grant) begin
      // x0 transfers are accepted but never presented as a write.
      r_reg_write  <= (w_win_rd != '0);
      r_rd         <= w_win_rd;
      r_write_data <= w_win_data;
    end else begin
      r_reg_write  <= 1'b0;
    end
  end

  // Set after clear: a newly issued producer supersedes the committing one.
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_reg_write && (r_rd != '0)) begin
      w_pending_nxt[r_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_pending_nxt[issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign reg_write  = r_reg_write;
  assign rd         = r_rd;
  assign write_data = r_write_data;
  assign pending    = r_pending;
  assign rs1_busy   = r_pending[rs1];
  assign rs2_busy   = r_pending[rs2];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_rf_wb_arbiter                                              |
// | Purpose  : Directed and randomized bench for rf_wb_arbiter against a     |
// |            cycle-level reference model of arbitration and scoreboard.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_valid = 1'b0, m_valid = 1'b0, issue_valid = 1'b0;
  logic        a_ready, m_ready, reg_write, rs1_busy, rs2_busy;
  logic [4:0]  a_rd = '0, m_rd = '0, issue_rd = '0, rs1 = '0, rs2 = '0, rd;
  logic [63:0] a_data = '0, m_data = '0, write_data;
  logic [31:0] pending;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] mdl_pend    = '0;
  bit          mdl_known   = 1'b0;
  bit          mdl_pref_m  = 1'b0;
  bit          exp_rw      = 1'b0;
  logic [4:0]  exp_rd      = '0;
  logic [63:0] exp_wd      = '0;
  bit          last_ag, last_mg;

  rf_wb_arbiter #(.XLEN(64), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_rd(m_rd), .m_data(m_data),
    .reg_write(reg_write), .rd(rd), .write_data(write_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit rst,
                      input bit av, input logic [4:0] ard, input logic [63:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [63:0] md,
                      input bit iv, input logic [4:0] ird,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit          eag, emg;
    logic [31:0] nxt;
    @(negedge clk);
    reset = rst; a_valid = av; a_rd = ard; a_data = ad;
    m_valid = mv; m_rd = mrd; m_data = md;
    issue_valid = iv; issue_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    eag = 1'b0; emg = 1'b0;
    if (!rst) begin
      if (av && mv) begin
`ifdef WB_RR_ARB_EN
        eag = !mdl_pref_m;
        emg = mdl_pref_m;
`else
        emg = 1'b1;
`endif
      end else begin
        eag = av;
        emg = mv;
      end
    end
    chk("a_ready", a_ready, eag);
    chk("m_ready", m_ready, emg);
    chk("ready_onehot", a_ready && m_ready, 0);
    if (mdl_known) begin
      chk("pending", pending, mdl_pend);
      chk("rs1_busy", rs1_busy, (r1 != 0) && mdl_pend[r1]);
      chk("rs2_busy", rs2_busy, (r2 != 0) && mdl_pend[r2]);
    end
    last_ag = eag;
    last_mg = emg;
    @(posedge clk);
    if (rst) begin
      mdl_pend = '0; mdl_known = 1'b1; mdl_pref_m = 1'b0;
      exp_rw = 1'b0; exp_rd = '0; exp_wd = '0;
    end else begin
      nxt = mdl_pend;
      if (exp_rw && exp_rd != 0) nxt[exp_rd] = 1'b0;
      if (iv && ird != 0) nxt[ird] = 1'b1;
      mdl_pend = nxt;
      if (eag) begin
        exp_rw = (ard != 0); exp_rd = ard; exp_wd = ad; mdl_pref_m = 1'b1;
      end else if (emg) begin
        exp_rw = (mrd != 0); exp_rd = mrd; exp_wd = md; mdl_pref_m = 1'b0;
      end else begin
        exp_rw = 1'b0;
      end
    end
    #1;
    chk("reg_write", reg_write, exp_rw);
    if (exp_rw || rst) begin
      chk("rd", rd, exp_rd);
      chk("write_data", write_data, exp_wd);
    end
  endtask

  task automatic idle(input logic [4:0] r1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 0);
  endtask

  initial begin
    bit          av = 0, mv = 0, a_hold = 0, m_hold = 0;
    logic [4:0]  ard = 0, mrd = 0;
    logic [63:0] ad = 0, md = 0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 64'h5, 1, 6, 64'h6, 1, 3, 0, 0);

    // Single ALU write-back to x5
    step(0, 1, 5, 64'h1234, 0, 0, 0, 0, 0, 5, 0);
    idle(0);
    idle(0);

    // Contention, 4 cycles, from a fresh arbitration state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      step(0, 1, 3, 64'hA0 + i, 1, 7, 64'hB0 + i, 0, 0, 3, 7);
    idle(0);

    // Load to x0: accepted, never written, scoreboard untouched
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    step(0, 0, 0, 0, 1, 0, 64'hFFFF, 0, 0, 2, 0);
    idle(2);

    // Issue x9, then ALU write-back to x9
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    idle(9);
    step(0, 1, 9, 64'h99, 0, 0, 0, 0, 0, 9, 0);
    idle(9);
    idle(9);

    // Re-issue of x9 on the commit edge keeps it pending
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 1, 9, 64'h77, 0, 0, 0, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(9);
    idle(9);

    // Reset mid-stream with pending bits and an in-flight write
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 2, 4);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 2, 4);
    step(0, 0, 0, 0, 1, 12, 64'hDEAD, 0, 0, 2, 4);
    step(1, 1, 6, 64'h66, 0, 0, 0, 1, 8, 2, 4);
    idle(2);

    // Randomized traffic; losing requesters hold their request
    for (int i = 0; i < 1500; i++) begin
      if (!a_hold) begin
        av = ($urandom_range(0, 2) != 0); ard = 5'($urandom_range(0, 9));
        ad = {$urandom, $urandom};
      end
      if (!m_hold) begin
        mv = ($urandom_range(0, 2) != 0); mrd = 5'($urandom_range(0, 9));
        md = {$urandom, $urandom};
      end
      step(($urandom_range(0, 63) == 0), av, ard, ad, mv, mrd, md,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 9)),
           5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
      a_hold = av && !last_ag;
      m_hold = mv && !last_mg;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
